// File: rtl/matrix_readout_if.sv
// Stream/control bundle for matrix_readout: snapshot request,
// valid/ready beat stream and the peak/done status outputs.
interface matrix_readout_if #(
    parameter int N_ENTRIES = 9,
    parameter int CNT_W     = 9
);
    logic [N_ENTRIES-1:0][CNT_W-1:0] matrix_in;
    logic                            start;
    logic                            busy;
    logic                            out_valid;
    logic                            out_ready;
    logic [CNT_W-1:0]                out_data;
    logic [3:0]                      out_idx;
    logic                            out_last;
    logic                            done;
    logic [CNT_W-1:0]                peak_val;
    logic [3:0]                      peak_idx;

    modport master (
        input  matrix_in, start, out_ready,
        output busy, out_valid, out_data, out_idx, out_last,
        output done, peak_val, peak_idx
    );

    modport slave (
        output matrix_in, start, out_ready,
        input  busy, out_valid, out_data, out_idx, out_last,
        input  done, peak_val, peak_idx
    );
endinterface

// File: rtl/matrix_readout.sv
// Snapshots the 3x3 hit-count matrix and streams it row-major with peak tracking.
// Define MATRIX_READOUT_CHECKSUM_EN to append an XOR checksum beat (idx 9).
module matrix_readout #(
    parameter int N_ENTRIES = 9,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    matrix_readout_if.master bus
);
    localparam logic [3:0] LAST_IDX = 4'(N_ENTRIES - 1);

    typedef logic [N_ENTRIES-1:0][CNT_W-1:0] mat_t;

`ifdef MATRIX_READOUT_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t           state_q, state_d;
    mat_t             snap_q, snap_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [3:0]       maxi_q, maxi_d;
    logic [CNT_W-1:0] pv_q, pv_d;
    logic [3:0]       pi_q, pi_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cur;
    logic             hs;

`ifdef MATRIX_READOUT_CHECKSUM_EN
    logic [CNT_W-1:0] xsum;

    // XOR of the frozen snapshot for the checksum beat
    always_comb begin
        xsum = '0;
        for (int k = 0; k < N_ENTRIES; k++) begin
            xsum = xsum ^ snap_q[k];
        end
    end
`endif

    assign cur = snap_q[idx_q];
    assign hs  = bus.out_valid && bus.out_ready;

    // State, snapshot and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            maxi_q  <= '0;
            pv_q    <= '0;
            pi_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            maxi_q  <= maxi_d;
            pv_q    <= pv_d;
            pi_q    <= pi_d;
            done_q  <= done_d;
        end
    end

    // Next-state, running-max update and beat outputs
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        idx_d         = idx_q;
        max_d         = max_q;
        maxi_d        = maxi_q;
        pv_d          = pv_q;
        pi_d          = pi_q;
        done_d        = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d  = bus.matrix_in;
                    idx_d   = '0;
                    max_d   = '0;
                    maxi_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                bus.out_valid = 1'b1;
                bus.out_data  = cur;
                bus.out_idx   = idx_q;
`ifndef MATRIX_READOUT_CHECKSUM_EN
                bus.out_last  = (idx_q == LAST_IDX);
`endif
                if (hs) begin
                    if (cur > max_q) begin
                        max_d  = cur;
                        maxi_d = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
`ifdef MATRIX_READOUT_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
                        pv_d    = max_d;
                        pi_d    = maxi_d;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`ifdef MATRIX_READOUT_CHECKSUM_EN
            CHK: begin
                bus.out_valid = 1'b1;
                bus.out_data  = xsum;
                bus.out_idx   = 4'd9;
                bus.out_last  = 1'b1;
                if (hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    pv_d    = max_q;
                    pi_d    = maxi_q;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.peak_val = pv_q;
    assign bus.peak_idx = pi_q;
endmodule

// File: tb/tb_matrix_readout.sv
// Randomized self-checking bench for matrix_readout against a frame-level model.
// Honors MATRIX_READOUT_CHECKSUM_EN when defined.
module tb_matrix_readout;
    localparam int N = 9;
    localparam int W = 9;
`ifdef MATRIX_READOUT_CHECKSUM_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif
    localparam int LIMIT = 400;

    typedef logic [N-1:0][W-1:0] mat_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    matrix_readout_if #(.N_ENTRIES(N), .CNT_W(W)) bus ();

    matrix_readout #(.N_ENTRIES(N), .CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: start, consume every beat per ready mode, check done/peak.
    // mode 0: ready always; 1: 1,0,0 repeating; 2: random.
    // abort_at >= 0 stops once that many beats have been handshaken.
    task automatic frame(input mat_t m, input int mode, input bit restart,
                         input int abort_at);
        logic [W-1:0] ed [NB];
        logic [3:0]   ei [NB];
        logic [W-1:0] x;
        logic [W-1:0] pv;
        logic [3:0]   pi;
        int           beat;
        int           cyc;
        bit           r;
        x  = '0;
        pv = '0;
        pi = '0;
        for (int k = 0; k < N; k++) begin
            ed[k] = m[k];
            ei[k] = 4'(k);
            x = x ^ m[k];
            if (m[k] > pv) begin
                pv = m[k];
                pi = 4'(k);
            end
        end
`ifdef MATRIX_READOUT_CHECKSUM_EN
        ed[N] = x;
        ei[N] = 4'd9;
`endif
        check("busy_before_start", bus.busy, 0);
        bus.matrix_in = m;
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < N; k++) bus.matrix_in[k] = W'($urandom);
        beat = 0;
        cyc  = 0;
        while (beat < NB && cyc < LIMIT) begin
            check("busy", bus.busy, 1);
            check("valid", bus.out_valid, 1);
            check("data", bus.out_data, ed[beat]);
            check("idx", bus.out_idx, ei[beat]);
            check("last", bus.out_last, beat == NB - 1);
            check("done_early", bus.done, 0);
            if (abort_at >= 0 && beat == abort_at) break;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.start     = restart && (beat == 4);
            bus.out_ready = r;
            @(negedge clk);
            if (r) beat++;
            cyc++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        if (cyc >= LIMIT) begin
            check("frame_timeout", 1, 0);
        end else if (abort_at < 0) begin
            check("done_pulse", bus.done, 1);
            check("busy_after", bus.busy, 0);
            check("valid_after", bus.out_valid, 0);
            check("peak_val", bus.peak_val, pv);
            check("peak_idx", bus.peak_idx, pi);
        end
    endtask

    // Cycle after done: pulse gone, nothing queued, peak held
    task automatic idle_after(input logic [W-1:0] pv, input logic [3:0] pi);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("no_queued_frame", bus.busy, 0);
        check("no_valid_idle", bus.out_valid, 0);
        check("peak_val_hold", bus.peak_val, pv);
        check("peak_idx_hold", bus.peak_idx, pi);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_last"}, bus.out_last, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_idx"}, bus.out_idx, 0);
        check({tag, "_pval"}, bus.peak_val, 0);
        check({tag, "_pidx"}, bus.peak_idx, 0);
    endtask

    initial begin
        mat_t m1, m3, mc, mf, mz, mr;
        logic [W-1:0] rp;
        logic [3:0]   ri;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.matrix_in = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < N; k++) m1[k] = W'(k * 10 + 1);
        frame(m1, 0, 1'b0, -1);
        idle_after(9'd81, 4'd8);
        frame(m1, 1, 1'b0, -1);
        idle_after(9'd81, 4'd8);

        m3 = '0;
        m3[0] = 9'd5;
        m3[1] = 9'd300;
        m3[2] = 9'd7;
        m3[3] = 9'd300;
        frame(m3, 2, 1'b0, -1);
        idle_after(9'd300, 4'd1);

        mf = '1;
        frame(m1, 0, 1'b1, -1);
        frame(mf, 0, 1'b0, -1);
        idle_after(9'd511, 4'd0);

        frame(m1, 0, 1'b0, 4);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("postreset");
        frame(m1, 0, 1'b0, -1);
        idle_after(9'd81, 4'd8);

        for (int k = 0; k < N; k++) mc[k] = W'(1 << k);
        frame(mc, 0, 1'b0, -1);
        idle_after(9'd256, 4'd8);

        mz = '0;
        frame(mz, 2, 1'b0, -1);
        idle_after(9'd0, 4'd0);

        for (int f = 0; f < 8; f++) begin
            rp = '0;
            ri = '0;
            for (int k = 0; k < N; k++) begin
                mr[k] = W'($urandom_range(0, 15) == 0 ? 511 : $urandom_range(0, 40));
                if (mr[k] > rp) begin
                    rp = mr[k];
                    ri = 4'(k);
                end
            end
            frame(mr, 2, 1'($urandom_range(0, 1)), -1);
            idle_after(rp, ri);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
